// File: rtl/ternary_seq_alu_if.sv
// Operand/result handshake bundle for ternary_seq_alu.
// valid/ready: a beat transfers on a rising edge where both valid and ready are high.
interface ternary_seq_alu_if #(
   parameter int N_TRITS = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_op;
   logic                   in_chain;
   logic [2*N_TRITS-1:0]   in_a;
   logic [2*N_TRITS-1:0]   in_b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*N_TRITS-1:0]   out_result;
   logic                   out_err;
   logic                   busy;

   modport slave (
      input  in_valid, in_op, in_chain, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_err, busy
   );

   modport master (
      output in_valid, in_op, in_chain, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_err, busy
   );
endinterface

// File: rtl/ternary_seq_alu.sv
// Multi-cycle trit-wise ALU (MIN/MAX/CONSENSUS/ANY), TRITS_PER_CYCLE trits per clock,
// with a chain mode that feeds the previous result back as operand B.
module ternary_seq_alu #(
   parameter int N_TRITS         = 8,
   parameter int TRITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   ternary_seq_alu_if.slave   bus,
   output logic [1:0]         dbg_state
);
   localparam int P      = TRITS_PER_CYCLE;
   localparam int W      = 2 * N_TRITS;
   localparam int GW     = 2 * P;
   localparam int GROUPS = N_TRITS / P;
   localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

   if (N_TRITS % TRITS_PER_CYCLE != 0) begin : g_bad_group
      $error("TRITS_PER_CYCLE must divide N_TRITS");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    a_q, b_q, work_q, result_q;
   logic [1:0]      op_q;
   logic            err_acc, err_q;
   logic            accept, last;
   logic [GW-1:0]   grp_a, grp_b, grp_r;
   logic            grp_err;
   logic [W-1:0]    work_nx;
   int unsigned     base;

   // Illegal codes (11) are treated as 0; every result is a legal code.
   function automatic logic [1:0] trit_op(input logic [1:0] op, input logic [1:0] a_raw,
                                          input logic [1:0] b_raw);
      logic [1:0] a, b, r;
      logic [2:0] s;
      a = (a_raw == 2'b11) ? 2'b00 : a_raw;
      b = (b_raw == 2'b11) ? 2'b00 : b_raw;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         2'b00:   r = (a < b) ? a : b;
         2'b01:   r = (a > b) ? a : b;
         2'b10:   r = (a == b) ? a : 2'b01;
         default: r = (s == 3'd0) ? 2'b00 : (s >= 3'd3) ? 2'b10 : (s[1:0] - 2'b01);
      endcase
      return r;
   endfunction

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (state == RUN) && (cnt == CW'(GROUPS - 1));

   always_comb begin
      base    = 32'(cnt) * 32'(GW);
      grp_a   = a_q[base +: GW];
      grp_b   = b_q[base +: GW];
      grp_r   = '0;
      grp_err = 1'b0;
      for (int j = 0; j < P; j++) begin
         grp_r[2*j +: 2] = trit_op(op_q, grp_a[2*j +: 2], grp_b[2*j +: 2]);
         grp_err = grp_err | (grp_a[2*j +: 2] == 2'b11) | (grp_b[2*j +: 2] == 2'b11);
      end
      work_nx = work_q;
      work_nx[base +: GW] = grp_r;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // result_q doubles as the chain source, so it only changes on the final RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= 2'b00;
         work_q   <= '0;
         result_q <= '0;
         err_acc  <= 1'b0;
         err_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.in_a;
         b_q     <= bus.in_chain ? result_q : bus.in_b;
         op_q    <= bus.in_op;
         cnt     <= '0;
         err_acc <= 1'b0;
      end else if (state == RUN) begin
         work_q  <= work_nx;
         err_acc <= err_acc | grp_err;
         cnt     <= cnt + CW'(1);
         if (last) begin
            result_q <= work_nx;
            err_q    <= err_acc | grp_err;
         end
      end
   end

   assign bus.in_ready   = (state == IDLE);
   assign bus.out_valid  = (state == DONE);
   assign bus.busy       = (state != IDLE);
   assign bus.out_result = result_q;
   assign bus.out_err    = err_q;
   assign dbg_state      = state;
endmodule

// File: tb/tb_ternary_seq_alu.sv
// Directed bench: three ternary_seq_alu instances (1, 2 and 4 trits per cycle) share
// one stimulus stream; each is checked against hand-computed results and latency.
module tb_ternary_seq_alu;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ternary_seq_alu_if #(.N_TRITS(N)) if1 ();
  ternary_seq_alu_if #(.N_TRITS(N)) if2 ();
  ternary_seq_alu_if #(.N_TRITS(N)) if4 ();
  logic [1:0] st1, st2, st4;

  ternary_seq_alu #(.N_TRITS(N), .TRITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .dbg_state(st1));
  ternary_seq_alu #(.N_TRITS(N), .TRITS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .dbg_state(st2));
  ternary_seq_alu #(.N_TRITS(N), .TRITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave), .dbg_state(st4));

  logic       in_valid, in_chain, out_ready;
  logic [1:0] in_op;
  logic [7:0] in_a, in_b;

  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;  assign if4.in_valid = in_valid;
  assign if1.in_op    = in_op;     assign if2.in_op    = in_op;     assign if4.in_op    = in_op;
  assign if1.in_chain = in_chain;  assign if2.in_chain = in_chain;  assign if4.in_chain = in_chain;
  assign if1.in_a     = in_a;      assign if2.in_a     = in_a;      assign if4.in_a     = in_a;
  assign if1.in_b     = in_b;      assign if2.in_b     = in_b;      assign if4.in_b     = in_b;
  assign if1.out_ready = out_ready; assign if2.out_ready = out_ready; assign if4.out_ready = out_ready;

  int checks = 0;
  int fails  = 0;
  logic [7:0] prev_r = 8'h00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/in_ready1"}, {7'd0, if1.in_ready}, 8'd1);
    chk({tag, "/in_ready2"}, {7'd0, if2.in_ready}, 8'd1);
    chk({tag, "/in_ready4"}, {7'd0, if4.in_ready}, 8'd1);
    chk({tag, "/out_valid1"}, {7'd0, if1.out_valid}, 8'd0);
    chk({tag, "/out_valid2"}, {7'd0, if2.out_valid}, 8'd0);
    chk({tag, "/out_valid4"}, {7'd0, if4.out_valid}, 8'd0);
    chk({tag, "/busy1"}, {7'd0, if1.busy}, 8'd0);
    chk({tag, "/busy4"}, {7'd0, if4.busy}, 8'd0);
  endtask

  task automatic chk_done(input string tag, input logic [7:0] exp_r, input logic exp_e);
    chk({tag, "/result1"}, if1.out_result, exp_r);
    chk({tag, "/result2"}, if2.out_result, exp_r);
    chk({tag, "/result4"}, if4.out_result, exp_r);
    chk({tag, "/err1"}, {7'd0, if1.out_err}, {7'd0, exp_e});
    chk({tag, "/err2"}, {7'd0, if2.out_err}, {7'd0, exp_e});
    chk({tag, "/err4"}, {7'd0, if4.out_err}, {7'd0, exp_e});
  endtask

  // One transaction: accept, latency per instance, result, optional DONE hold, release.
  task automatic run_op(input string tag, input logic [1:0] op, input logic chain,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_r, input logic exp_e, input int hold);
    in_valid = 1'b1; in_op = op; in_chain = chain; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'hEE; in_b = 8'hEE; in_op = 2'b11; in_chain = 1'b0;
    chk({tag, "/accept_in_ready1"}, {7'd0, if1.in_ready}, 8'd0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      chk({tag, "/lat_valid1"}, {7'd0, if1.out_valid}, {7'd0, (e >= 4)});
      chk({tag, "/lat_valid2"}, {7'd0, if2.out_valid}, {7'd0, (e >= 2)});
      chk({tag, "/lat_valid4"}, {7'd0, if4.out_valid}, 8'd1);
      if (e < 4) chk({tag, "/prev_result1"}, if1.out_result, prev_r);
    end
    chk_done(tag, exp_r, exp_e);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a = 8'($urandom_range(0, 255));
      in_b = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk_done({tag, "/hold"}, exp_r, exp_e);
      chk({tag, "/hold_valid1"}, {7'd0, if1.out_valid}, 8'd1);
      chk({tag, "/hold_valid4"}, {7'd0, if4.out_valid}, 8'd1);
      chk({tag, "/hold_in_ready2"}, {7'd0, if2.in_ready}, 8'd0);
      chk({tag, "/hold_busy1"}, {7'd0, if1.busy}, 8'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_idle({tag, "/release"});
    chk({tag, "/release_state1"}, {6'd0, st1}, 8'd0);
    prev_r = exp_r;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_chain = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_a = 8'h00; in_b = 8'h00;
    #1;
    chk_idle("reset");
    chk("reset/result1", if1.out_result, 8'h00);
    chk("reset/err1", {7'd0, if1.out_err}, 8'd0);
    chk("reset/state1", {6'd0, st1}, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op("max",       2'b01, 1'b0, 8'h91, 8'h1A, 8'h9A, 1'b0, 0);
    run_op("chain_any", 2'b11, 1'b1, 8'h00, 8'hFF, 8'h45, 1'b0, 0);
    run_op("min",       2'b00, 1'b0, 8'h91, 8'h1A, 8'h11, 1'b0, 0);
    run_op("cons",      2'b10, 1'b0, 8'h91, 8'h1A, 8'h55, 1'b0, 0);
    run_op("any",       2'b11, 1'b0, 8'h91, 8'h1A, 8'h56, 1'b0, 0);
    run_op("stored",    2'b01, 1'b1, 8'h00, 8'h00, 8'h56, 1'b0, 0);
    run_op("illegal",   2'b01, 1'b0, 8'hFF, 8'h1A, 8'h1A, 1'b1, 3);
    run_op("legal",     2'b00, 1'b0, 8'h91, 8'h1A, 8'h11, 1'b0, 0);

    // Reset with the 1-trit instance mid-RUN at group counter 2.
    in_valid = 1'b1; in_op = 2'b00; in_chain = 1'b0; in_a = 8'h91; in_b = 8'h1A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("midrun/state1", {6'd0, st1}, 8'd1);
    rst = 1'b1;
    #1;
    chk_idle("midrun_rst");
    chk("midrun_rst/result1", if1.out_result, 8'h00);
    chk("midrun_rst/err1", {7'd0, if1.out_err}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post_rst/valid1", {7'd0, if1.out_valid}, 8'd0);
    end
    prev_r = 8'h00;
    run_op("chain_after_rst", 2'b11, 1'b1, 8'h91, 8'hFF, 8'h40, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
